// File: rtl/decode_issue_stage_pkg.sv
// Shared opcode numbering, RV32I major opcodes and immediate formats for the decode/issue stage.
package decode_issue_stage_pkg;

    typedef enum logic [5:0] {
        OPNUM_NOP, OPNUM_LUI, OPNUM_AUIPC, OPNUM_JAL, OPNUM_JALR,
        OPNUM_BEQ, OPNUM_BNE, OPNUM_BLT, OPNUM_BGE, OPNUM_BLTU, OPNUM_BGEU,
        OPNUM_LB, OPNUM_LH, OPNUM_LW, OPNUM_LBU, OPNUM_LHU,
        OPNUM_SB, OPNUM_SH, OPNUM_SW,
        OPNUM_ADDI, OPNUM_SLTI, OPNUM_SLTIU, OPNUM_XORI, OPNUM_ORI, OPNUM_ANDI,
        OPNUM_SLLI, OPNUM_SRLI, OPNUM_SRAI,
        OPNUM_ADD, OPNUM_SUB, OPNUM_SLL, OPNUM_SLT, OPNUM_SLTU, OPNUM_XOR,
        OPNUM_SRL, OPNUM_SRA, OPNUM_OR, OPNUM_AND
    } opnum_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_RI    = 7'b0010011;
    localparam logic [6:0] OP_RR    = 7'b0110011;

    localparam logic [6:0] FUNC7_BASE = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    // Queue entry layout: {pred_br, pc, inst}
    localparam int Q_W = 65;

endpackage

// File: rtl/decode_issue_stage_inst_queue.sv
// Instruction FIFO between fetch and decode; callers pre-qualify push/pop against full/empty.
module inst_queue
    import decode_issue_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = Q_W
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: buffers fetched instructions, decodes the queue head, resolves operands
// through regfile -> ROB -> CDB, and registers one issue per cycle towards the RS or the LSB.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int NUM_CDB     = 2,
    parameter int ROB_IDX_W   = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clr_in,
    input  logic                         if_valid,
    input  logic [31:0]                  if_inst,
    input  logic [31:0]                  if_pc,
    input  logic                         if_pred_br,
    output logic                         if_ready,
    input  logic                         rob_full,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    output logic [4:0]                   reg_rs1_pos,
    output logic [4:0]                   reg_rs2_pos,
    input  logic [31:0]                  reg_rs1_val,
    input  logic [31:0]                  reg_rs2_val,
    input  logic [ROB_IDX_W-1:0]         reg_rs1_dep,
    input  logic [ROB_IDX_W-1:0]         reg_rs2_dep,
    output logic [ROB_IDX_W-1:0]         rob_rs1_check,
    output logic [ROB_IDX_W-1:0]         rob_rs2_check,
    input  logic                         rob_rs1_ready,
    input  logic [31:0]                  rob_rs1_val,
    input  logic                         rob_rs2_ready,
    input  logic [31:0]                  rob_rs2_val,
    input  logic [ROB_IDX_W-1:0]         rob_rename_idx,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_idx,
    input  logic [NUM_CDB*32-1:0]        cdb_val,
    output logic                         issue_valid,
    output logic                         issue_to_rs,
    output logic                         issue_to_lsb,
    output logic [ROB_IDX_W-1:0]         issue_rob_idx,
    output logic [5:0]                   issue_op,
    output logic [4:0]                   issue_rd,
    output logic [31:0]                  issue_imm,
    output logic [31:0]                  issue_pc,
    output logic                         issue_pred_br,
    output logic [31:0]                  issue_rs1_val,
    output logic [31:0]                  issue_rs2_val,
    output logic [ROB_IDX_W-1:0]         issue_rs1_dep,
    output logic [ROB_IDX_W-1:0]         issue_rs2_dep,
    output logic                         illegal_inst
);
    localparam int RW = ROB_IDX_W + 32;

    logic [Q_W-1:0] head;
    logic [31:0]    inst;
    logic [31:0]    head_pc;
    logic           head_pred;
    logic           q_full, q_empty, push_fire, pop_fire, stall;
    logic [2:0]     f3;
    logic [6:0]     f7;
    opnum_t         op;
    imm_fmt_t       fmt;
    logic           legal, use_rs1, use_rs2, use_rd, to_lsb;
    logic [31:0]    imm;
    logic [RW-1:0]  rs1_res, rs2_res;

    assign {head_pred, head_pc, inst} = head;
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];

    assign if_ready  = !q_full;
    assign push_fire = if_valid && !q_full && rdy_in && !clr_in;

    inst_queue #(.DEPTH(QUEUE_DEPTH), .W(Q_W)) u_queue (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (rdy_in && clr_in),
        .push   (push_fire),
        .pop    (pop_fire),
        .wdata  ({if_pred_br, if_pc, if_inst}),
        .rdata  (head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_comb begin
        op      = OPNUM_NOP;
        fmt     = FMT_R;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        to_lsb  = 1'b0;
        case (inst[6:0])
            OP_LUI:   begin op = OPNUM_LUI;   fmt = FMT_U; use_rs1 = 1'b0; use_rs2 = 1'b0; end
            OP_AUIPC: begin op = OPNUM_AUIPC; fmt = FMT_U; use_rs1 = 1'b0; use_rs2 = 1'b0; end
            OP_JAL:   begin op = OPNUM_JAL;   fmt = FMT_J; use_rs1 = 1'b0; use_rs2 = 1'b0; end
            OP_JALR: begin
                op = OPNUM_JALR; fmt = FMT_I; use_rs2 = 1'b0;
                legal = (f3 == 3'd0);
            end
            OP_BR: begin
                fmt = FMT_B; use_rd = 1'b0;
                case (f3)
                    3'd0: op = OPNUM_BEQ;
                    3'd1: op = OPNUM_BNE;
                    3'd4: op = OPNUM_BLT;
                    3'd5: op = OPNUM_BGE;
                    3'd6: op = OPNUM_BLTU;
                    3'd7: op = OPNUM_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LD: begin
                fmt = FMT_I; use_rs2 = 1'b0; to_lsb = 1'b1;
                case (f3)
                    3'd0: op = OPNUM_LB;
                    3'd1: op = OPNUM_LH;
                    3'd2: op = OPNUM_LW;
                    3'd4: op = OPNUM_LBU;
                    3'd5: op = OPNUM_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OP_ST: begin
                fmt = FMT_S; use_rd = 1'b0; to_lsb = 1'b1;
                case (f3)
                    3'd0: op = OPNUM_SB;
                    3'd1: op = OPNUM_SH;
                    3'd2: op = OPNUM_SW;
                    default: legal = 1'b0;
                endcase
            end
            OP_RI: begin
                fmt = FMT_I; use_rs2 = 1'b0;
                case (f3)
                    3'd0: op = OPNUM_ADDI;
                    3'd2: op = OPNUM_SLTI;
                    3'd3: op = OPNUM_SLTIU;
                    3'd4: op = OPNUM_XORI;
                    3'd6: op = OPNUM_ORI;
                    3'd7: op = OPNUM_ANDI;
                    3'd1: if (f7 == FUNC7_BASE) op = OPNUM_SLLI; else legal = 1'b0;
                    default: begin
                        if (f7 == FUNC7_BASE)     op = OPNUM_SRLI;
                        else if (f7 == FUNC7_ALT) op = OPNUM_SRAI;
                        else                      legal = 1'b0;
                    end
                endcase
            end
            OP_RR: begin
                case ({f7, f3})
                    {FUNC7_BASE, 3'd0}: op = OPNUM_ADD;
                    {FUNC7_ALT,  3'd0}: op = OPNUM_SUB;
                    {FUNC7_BASE, 3'd1}: op = OPNUM_SLL;
                    {FUNC7_BASE, 3'd2}: op = OPNUM_SLT;
                    {FUNC7_BASE, 3'd3}: op = OPNUM_SLTU;
                    {FUNC7_BASE, 3'd4}: op = OPNUM_XOR;
                    {FUNC7_BASE, 3'd5}: op = OPNUM_SRL;
                    {FUNC7_ALT,  3'd5}: op = OPNUM_SRA;
                    {FUNC7_BASE, 3'd6}: op = OPNUM_OR;
                    {FUNC7_BASE, 3'd7}: op = OPNUM_AND;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'd0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    // Returns {dep, val}; dep is zero whenever a value was found. Lowest CDB channel wins.
    function automatic logic [RW-1:0] resolve(
        input logic [ROB_IDX_W-1:0]         dep,
        input logic [31:0]                  reg_val,
        input logic                         rob_ready,
        input logic [31:0]                  rob_val,
        input logic [NUM_CDB-1:0]           cv,
        input logic [NUM_CDB*ROB_IDX_W-1:0] ci,
        input logic [NUM_CDB*32-1:0]        cd
    );
        logic [RW-1:0] r;
        if (dep == '0) begin
            r = {{ROB_IDX_W{1'b0}}, reg_val};
        end else if (rob_ready) begin
            r = {{ROB_IDX_W{1'b0}}, rob_val};
        end else begin
            r = {dep, 32'd0};
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cv[k] && ci[k*ROB_IDX_W +: ROB_IDX_W] == dep)
                    r = {{ROB_IDX_W{1'b0}}, cd[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign rs1_res = use_rs1 ? resolve(reg_rs1_dep, reg_rs1_val, rob_rs1_ready, rob_rs1_val,
                                       cdb_valid, cdb_idx, cdb_val) : '0;
    assign rs2_res = use_rs2 ? resolve(reg_rs2_dep, reg_rs2_val, rob_rs2_ready, rob_rs2_val,
                                       cdb_valid, cdb_idx, cdb_val) : '0;

    assign reg_rs1_pos   = use_rs1 ? inst[19:15] : 5'd0;
    assign reg_rs2_pos   = use_rs2 ? inst[24:20] : 5'd0;
    assign rob_rs1_check = reg_rs1_dep;
    assign rob_rs2_check = reg_rs2_dep;

    // An illegal head needs neither a target slot nor a ROB tag, so it never stalls.
    assign stall    = rob_full || (to_lsb ? lsb_full : rs_full);
    assign pop_fire = !q_empty && rdy_in && !clr_in && (!legal || !stall);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            issue_valid   <= 1'b0;
            issue_to_rs   <= 1'b0;
            issue_to_lsb  <= 1'b0;
            illegal_inst  <= 1'b0;
            issue_rob_idx <= '0;
            issue_op      <= OPNUM_NOP;
            issue_rd      <= '0;
            issue_imm     <= '0;
            issue_pc      <= '0;
            issue_pred_br <= 1'b0;
            issue_rs1_val <= '0;
            issue_rs2_val <= '0;
            issue_rs1_dep <= '0;
            issue_rs2_dep <= '0;
        end else if (rdy_in) begin
            if (pop_fire && legal) begin
                issue_valid   <= 1'b1;
                issue_to_rs   <= !to_lsb;
                issue_to_lsb  <= to_lsb;
                illegal_inst  <= 1'b0;
                issue_rob_idx <= rob_rename_idx;
                issue_op      <= op;
                issue_rd      <= use_rd ? inst[11:7] : 5'd0;
                issue_imm     <= imm;
                issue_pc      <= head_pc;
                issue_pred_br <= head_pred;
                {issue_rs1_dep, issue_rs1_val} <= rs1_res;
                {issue_rs2_dep, issue_rs2_val} <= rs2_res;
            end else begin
                issue_valid  <= 1'b0;
                issue_to_rs  <= 1'b0;
                issue_to_lsb <= 1'b0;
                illegal_inst <= pop_fire;
            end
        end
    end

endmodule
